sdram_port_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 16-bit Avalon-MM master port to SDRAM between two

---
 rtl/sdram_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_port_arbiter
//  Purpose  : Round-robin arbiter that shares one 16-bit Avalon-MM SDRAM
//             master port between two client masters (c0, c1). The owning
//             client is forwarded straight through; the other is stalled
//             with waitrequest. A hold limit bounds how many back-to-back
//             transfers one client may issue while the other is waiting.
//  Ports    : clk, reset (async, active-high)
//             c0_* / c1_* : client Avalon-MM slave side (address, read,
//                           write, writedata, readdata, waitrequest)
//             m_*         : SDRAM-facing Avalon-MM master side
//             grant       : registered one-hot owner {c1,c0}, 00 = idle
//  Revision : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter #(
   parameter int unsigned HOLD_MAX = 16   // 1..255
) (
   input  logic        clk,
   input  logic        reset,
   // client 0
   input  logic [31:0] c0_address,
   input  logic        c0_read,
   input  logic        c0_write,
   input  logic [15:0] c0_writedata,
   output logic [15:0] c0_readdata,
   output logic        c0_waitrequest,
   // client 1
   input  logic [31:0] c1_address,
   input  logic        c1_read,
   input  logic        c1_write,
   input  logic [15:0] c1_writedata,
   output logic [15:0] c1_readdata,
   output logic        c1_waitrequest,
   // SDRAM port
   output logic [31:0] m_address,
   output logic        m_read,
   output logic        m_write,
   output logic [15:0] m_writedata,
   input  logic [15:0] m_readdata,
   input  logic        m_waitrequest,
   // owner
   output logic [1:0]  grant
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   localparam logic [8:0] HOLD_LIM = 9'(HOLD_MAX);

   state_t     state_q, state_d;
   logic       last_q, last_d;          // previous owner: 0 = c0, 1 = c1
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic [1:0] grant_q, grant_d;

   logic       req0, req1;
   logic       own_id;                  // index of the current owner
   logic       own_req, oth_req;
   state_t     oth_state;
   logic [8:0] cnt_inc;                 // one bit wider so the limit compare cannot wrap

   assign req0      = c0_read | c0_write;
   assign req1      = c1_read | c1_write;
   assign own_id    = (state_q == OWN1);
   assign own_req   = own_id ? req1 : req0;
   assign oth_req   = own_id ? req0 : req1;
   assign oth_state = own_id ? OWN0 : OWN1;
   assign cnt_inc   = {1'b0, hold_cnt_q} + 9'd1;

   // ------------------------------------------------------------------------
   // Next-state / arbitration
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         IDLE: begin
            hold_cnt_d = 8'd0;
            if (req0 && req1) begin
               // tie goes to whichever client did not own the port last
               state_d = last_q ? OWN0 : OWN1;
            end else if (req0) begin
               state_d = OWN0;
            end else if (req1) begin
               state_d = OWN1;
            end
         end
         OWN0, OWN1: begin
            if (!own_req) begin
               // owner released (or abandoned an unaccepted request)
               state_d    = oth_req ? oth_state : IDLE;
               last_d     = own_id;
               hold_cnt_d = 8'd0;
            end else if (!m_waitrequest) begin
               if ((cnt_inc >= HOLD_LIM) && oth_req) begin
                  // hold budget spent and the other side is waiting: hand over
                  state_d    = oth_state;
                  last_d     = own_id;
                  hold_cnt_d = 8'd0;
               end else if (cnt_inc >= HOLD_LIM) begin
                  hold_cnt_d = HOLD_LIM[7:0];
               end else begin
                  hold_cnt_d = cnt_inc[7:0];
               end
            end
            // reqX & m_waitrequest: hold everything so m_* stays stable
         end
         default: begin
            state_d    = IDLE;
            hold_cnt_d = 8'd0;
         end
      endcase
      grant_d = {state_d == OWN1, state_d == OWN0};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         last_q     <= 1'b1;
         hold_cnt_q <= 8'd0;
         grant_q    <= 2'b00;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         hold_cnt_q <= hold_cnt_d;
         grant_q    <= grant_d;
      end
   end

   assign grant = grant_q;

   // ------------------------------------------------------------------------
   // Datapath mux: owner sees the SDRAM port directly, the other is stalled.
   // Write dominates when a client asserts read and write together.
   // ------------------------------------------------------------------------
   always_comb begin
      m_address      = 32'd0;
      m_read         = 1'b0;
      m_write        = 1'b0;
      m_writedata    = 16'd0;
      c0_readdata    = 16'd0;
      c1_readdata    = 16'd0;
      c0_waitrequest = 1'b1;
      c1_waitrequest = 1'b1;
      case (state_q)
         OWN0: begin
            m_address      = c0_address;
            m_read         = c0_read & ~c0_write;
            m_write        = c0_write;
            m_writedata    = c0_writedata;
            c0_readdata    = m_readdata;
            c0_waitrequest = m_waitrequest;
         end
         OWN1: begin
            m_address      = c1_address;
            m_read         = c1_read & ~c1_write;
            m_write        = c1_write;
            m_writedata    = c1_writedata;
            c1_readdata    = m_readdata;
            c1_waitrequest = m_waitrequest;
         end
         default: begin
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_port_arbiter
//  Purpose  : Self-checking bench for sdram_port_arbiter (HOLD_MAX = 4).
//             A small SDRAM model returns data derived from the address;
//             expected transfers are queued as they are issued and checked
//             when the DUT completes them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arbiter;

   localparam int HOLD = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] c0_address, c1_address, m_address;
   logic        c0_read, c0_write, c1_read, c1_write, m_read, m_write;
   logic [15:0] c0_writedata, c1_writedata, m_writedata;
   logic [15:0] c0_readdata, c1_readdata, m_readdata;
   logic        c0_waitrequest, c1_waitrequest, m_waitrequest;
   logic [1:0]  grant;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] addr;
      logic [15:0] data;
   } xfer_t;
   xfer_t sb_q[$];

   function automatic logic [15:0] mem_rd(input logic [31:0] a);
      return a[15:0] ^ a[31:16] ^ 16'h5A5A;
   endfunction

   assign m_readdata = mem_rd(m_address);

   always #5 clk = ~clk;

   sdram_port_arbiter #(.HOLD_MAX(HOLD)) dut (
      .clk(clk), .reset(reset),
      .c0_address(c0_address), .c0_read(c0_read), .c0_write(c0_write),
      .c0_writedata(c0_writedata), .c0_readdata(c0_readdata),
      .c0_waitrequest(c0_waitrequest),
      .c1_address(c1_address), .c1_read(c1_read), .c1_write(c1_write),
      .c1_writedata(c1_writedata), .c1_readdata(c1_readdata),
      .c1_waitrequest(c1_waitrequest),
      .m_address(m_address), .m_read(m_read), .m_write(m_write),
      .m_writedata(m_writedata), .m_readdata(m_readdata),
      .m_waitrequest(m_waitrequest), .grant(grant)
   );

   task automatic clear_inputs();
      c0_address = 32'd0; c0_read = 1'b0; c0_write = 1'b0; c0_writedata = 16'd0;
      c1_address = 32'd0; c1_read = 1'b0; c1_write = 1'b0; c1_writedata = 16'd0;
      m_waitrequest = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant got %b exp 00", grant); end
      checks++; if (m_read !== 1'b0 || m_write !== 1'b0) begin errors++; $display("FAIL rst_rdwr got %b%b exp 00", m_read, m_write); end
      checks++; if (c0_waitrequest !== 1'b1 || c1_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_wait got %b%b exp 11", c0_waitrequest, c1_waitrequest); end
      checks++; if (m_address !== 32'd0) begin errors++; $display("FAIL rst_addr got %h exp 0", m_address); end
      @(posedge clk); #1 reset = 1'b0;
   endtask

   // c0 reads four words through a port that stalls every other cycle
   task automatic test_single_read();
      int acc = 0;
      bit acc_prev = 1'b0;
      xfer_t e;
      @(posedge clk); #1;
      c0_address = 32'h40; c0_read = 1'b1; m_waitrequest = 1'b0;
      sb_q.push_back('{addr: c0_address, data: mem_rd(c0_address)});
      @(negedge clk);
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL t1_grant_first got %b exp 00", grant); end
      checks++; if (c0_waitrequest !== 1'b1) begin errors++; $display("FAIL t1_wait_first got %b exp 1", c0_waitrequest); end
      for (int cyc = 0; cyc < 40 && acc < 4; cyc++) begin
         @(posedge clk); #1;
         if (acc_prev) begin
            c0_address = c0_address + 32'd2;
            sb_q.push_back('{addr: c0_address, data: mem_rd(c0_address)});
         end
         m_waitrequest = (cyc % 2 == 0);
         @(negedge clk);
         checks++; if (grant !== 2'b01) begin errors++; $display("FAIL t1_grant got %b exp 01", grant); end
         checks++; if (c1_waitrequest !== 1'b1) begin errors++; $display("FAIL t1_c1wait got %b exp 1", c1_waitrequest); end
         checks++; if (c1_readdata !== 16'd0) begin errors++; $display("FAIL t1_c1rd got %h exp 0", c1_readdata); end
         checks++; if (c0_waitrequest !== m_waitrequest) begin errors++; $display("FAIL t1_c0wait got %b exp %b", c0_waitrequest, m_waitrequest); end
         checks++; if (m_read !== 1'b1 || m_address !== c0_address) begin errors++; $display("FAIL t1_mreq got rd=%b a=%h exp rd=1 a=%h", m_read, m_address, c0_address); end
         acc_prev = 1'b0;
         if (c0_waitrequest === 1'b0) begin
            checks++;
            if (sb_q.size() == 0) begin errors++; $display("FAIL t1_sb_empty got accept exp none"); end
            else begin
               e = sb_q.pop_front();
               if (c0_readdata !== e.data) begin errors++; $display("FAIL t1_rdata got %h exp %h", c0_readdata, e.data); end
            end
            acc++;
            acc_prev = 1'b1;
         end
      end
      checks++; if (acc != 4) begin errors++; $display("FAIL t1_accepts got %0d exp 4", acc); end
      @(posedge clk); #1 c0_read = 1'b0; m_waitrequest = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   // simultaneous requests after reset: c0 first, c1 right after c0 releases
   task automatic test_tie_after_reset();
      int acc = 0;
      bit acc_prev = 1'b0;
      xfer_t e;
      apply_reset();
      @(posedge clk); #1;
      c0_write = 1'b1; c0_address = 32'h200; c0_writedata = 16'h1111;
      c1_write = 1'b1; c1_address = 32'h400; c1_writedata = 16'h2222;
      sb_q.push_back('{addr: c0_address, data: c0_writedata});
      @(negedge clk);
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL t2_grant_first got %b exp 00", grant); end
      for (int cyc = 0; cyc < 10 && acc < 3; cyc++) begin
         @(posedge clk); #1;
         if (acc_prev) begin
            c0_address = c0_address + 32'd2; c0_writedata = c0_writedata + 16'd1;
            sb_q.push_back('{addr: c0_address, data: c0_writedata});
         end
         @(negedge clk);
         checks++; if (grant !== 2'b01 || c1_waitrequest !== 1'b1) begin errors++; $display("FAIL t2_own0 got g=%b w1=%b exp g=01 w1=1", grant, c1_waitrequest); end
         acc_prev = 1'b0;
         if (m_write === 1'b1 && m_waitrequest === 1'b0) begin
            checks++;
            if (sb_q.size() == 0) begin errors++; $display("FAIL t2_sb_empty got write exp none"); end
            else begin
               e = sb_q.pop_front();
               if (m_address !== e.addr || m_writedata !== e.data) begin errors++; $display("FAIL t2_wr got %h/%h exp %h/%h", m_address, m_writedata, e.addr, e.data); end
            end
            acc++;
            acc_prev = 1'b1;
         end
      end
      checks++; if (acc != 3) begin errors++; $display("FAIL t2_accepts got %0d exp 3", acc); end
      @(posedge clk); #1 c0_write = 1'b0;
      sb_q.push_back('{addr: c1_address, data: c1_writedata});
      @(negedge clk);
      checks++; if (grant !== 2'b01 || m_write !== 1'b0) begin errors++; $display("FAIL t2_release got g=%b w=%b exp g=01 w=0", grant, m_write); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (grant !== 2'b10 || c1_waitrequest !== 1'b0) begin errors++; $display("FAIL t2_own1 got g=%b w1=%b exp g=10 w1=0", grant, c1_waitrequest); end
      checks++;
      if (sb_q.size() == 0) begin errors++; $display("FAIL t2_sb_empty1 got write exp none"); end
      else begin
         e = sb_q.pop_front();
         if (m_write !== 1'b1 || m_address !== e.addr || m_writedata !== e.data) begin errors++; $display("FAIL t2_c1wr got %b %h/%h exp 1 %h/%h", m_write, m_address, m_writedata, e.addr, e.data); end
      end
      @(posedge clk); #1 c1_write = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   // both stream writes: ownership flips every HOLD accepts with no idle cycle
   task automatic test_hold_limit();
      int n0 = 0, n1 = 0, e0 = 0, e1 = 0;
      bit adv0 = 1'b0, adv1 = 1'b0;
      logic [1:0]  exp_g;
      logic [31:0] exp_a;
      apply_reset();
      @(posedge clk); #1;
      c0_write = 1'b1; c0_address = 32'h1000; c0_writedata = 16'hC000;
      c1_write = 1'b1; c1_address = 32'h2000; c1_writedata = 16'hD000;
      @(negedge clk);
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL t3_grant_first got %b exp 00", grant); end
      for (int k = 0; k < 32; k++) begin
         @(posedge clk); #1;
         if (adv0) begin c0_address = c0_address + 32'd2; c0_writedata = c0_writedata + 16'd1; end
         if (adv1) begin c1_address = c1_address + 32'd2; c1_writedata = c1_writedata + 16'd1; end
         adv0 = 1'b0; adv1 = 1'b0;
         @(negedge clk);
         exp_g = (((k / HOLD) % 2) == 0) ? 2'b01 : 2'b10;
         exp_a = exp_g[0] ? (32'h1000 + 32'(2 * e0)) : (32'h2000 + 32'(2 * e1));
         if (exp_g[0]) e0++; else e1++;
         checks++; if (grant !== exp_g) begin errors++; $display("FAIL t3_grant k=%0d got %b exp %b", k, grant, exp_g); end
         checks++; if (m_write !== 1'b1 || m_address !== exp_a) begin errors++; $display("FAIL t3_xfer k=%0d got w=%b a=%h exp w=1 a=%h", k, m_write, m_address, exp_a); end
         if (c0_waitrequest === 1'b0) begin n0++; adv0 = 1'b1; end
         if (c1_waitrequest === 1'b0) begin n1++; adv1 = 1'b1; end
      end
      checks++; if (n0 != 16 || n1 != 16) begin errors++; $display("FAIL t3_totals got %0d/%0d exp 16/16", n0, n1); end
      @(posedge clk); #1 c0_write = 1'b0; c1_write = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   // a stalled write must not be preempted and must stay stable until accepted
   task automatic test_stall_no_switch();
      int acc = 0;
      xfer_t e;
      apply_reset();
      @(posedge clk); #1;
      c0_write = 1'b1; c0_address = 32'h100; c0_writedata = 16'hA5A5;
      c1_read = 1'b1; c1_address = 32'h300; m_waitrequest = 1'b1;
      sb_q.push_back('{addr: c0_address, data: c0_writedata});
      @(negedge clk);
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL t4_grant_first got %b exp 00", grant); end
      for (int cyc = 0; cyc < 11; cyc++) begin
         @(posedge clk); #1;
         m_waitrequest = (cyc < 10);
         @(negedge clk);
         checks++; if (grant !== 2'b01 || c1_waitrequest !== 1'b1) begin errors++; $display("FAIL t4_hold cyc=%0d got g=%b w1=%b exp g=01 w1=1", cyc, grant, c1_waitrequest); end
         checks++; if (m_write !== 1'b1 || m_address !== 32'h100 || m_writedata !== 16'hA5A5) begin errors++; $display("FAIL t4_stable cyc=%0d got %b %h/%h exp 1 100/a5a5", cyc, m_write, m_address, m_writedata); end
         if (m_write === 1'b1 && m_waitrequest === 1'b0) begin
            checks++;
            if (sb_q.size() == 0) begin errors++; $display("FAIL t4_sb_empty got write exp none"); end
            else begin
               e = sb_q.pop_front();
               if (m_writedata !== e.data) begin errors++; $display("FAIL t4_wdata got %h exp %h", m_writedata, e.data); end
            end
            acc++;
         end
      end
      checks++; if (acc != 1) begin errors++; $display("FAIL t4_accepts got %0d exp 1", acc); end
      @(posedge clk); #1;
      c0_write = 1'b0; m_waitrequest = 1'b0;
      sb_q.push_back('{addr: c1_address, data: mem_rd(c1_address)});
      @(negedge clk);
      checks++; if (grant !== 2'b01) begin errors++; $display("FAIL t4_release got %b exp 01", grant); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (grant !== 2'b10 || m_read !== 1'b1 || m_address !== 32'h300) begin errors++; $display("FAIL t4_own1 got g=%b r=%b a=%h exp g=10 r=1 a=300", grant, m_read, m_address); end
      checks++;
      if (sb_q.size() == 0) begin errors++; $display("FAIL t4_sb_empty1 got read exp none"); end
      else begin
         e = sb_q.pop_front();
         if (c1_readdata !== e.data || c1_waitrequest !== 1'b0) begin errors++; $display("FAIL t4_c1rd got %h w=%b exp %h w=0", c1_readdata, c1_waitrequest, e.data); end
      end
   endtask

   // asynchronous reset in the middle of a stalled c1 read
   task automatic test_reset_mid_transfer();
      @(posedge clk); #1;
      m_waitrequest = 1'b1; c1_address = 32'h302;
      c0_read = 1'b1; c0_address = 32'h500;
      @(negedge clk);
      checks++; if (grant !== 2'b10 || m_read !== 1'b1) begin errors++; $display("FAIL t5_pre got g=%b r=%b exp g=10 r=1", grant, m_read); end
      reset = 1'b1;
      #1;
      checks++; if (m_read !== 1'b0 || m_address !== 32'd0) begin errors++; $display("FAIL t5_mport got r=%b a=%h exp r=0 a=0", m_read, m_address); end
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL t5_grant got %b exp 00", grant); end
      checks++; if (c0_waitrequest !== 1'b1 || c1_waitrequest !== 1'b1) begin errors++; $display("FAIL t5_wait got %b%b exp 11", c0_waitrequest, c1_waitrequest); end
      @(posedge clk); #1;
      reset = 1'b0; m_waitrequest = 1'b0;
      @(negedge clk);
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL t5_idle got %b exp 00", grant); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (grant !== 2'b01 || m_address !== 32'h500) begin errors++; $display("FAIL t5_tie got g=%b a=%h exp g=01 a=500", grant, m_address); end
      checks++; if (c0_readdata !== mem_rd(32'h500)) begin errors++; $display("FAIL t5_rdata got %h exp %h", c0_readdata, mem_rd(32'h500)); end
      @(posedge clk); #1 c0_read = 1'b0; c1_read = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   // read and write asserted together: the write wins
   task automatic test_rw_both();
      @(posedge clk); #1;
      c0_read = 1'b1; c0_write = 1'b1; c0_address = 32'h600; c0_writedata = 16'h3C3C;
      @(negedge clk);
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL t6_grant_first got %b exp 00", grant); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (m_write !== 1'b1 || m_read !== 1'b0) begin errors++; $display("FAIL t6_rw got w=%b r=%b exp w=1 r=0", m_write, m_read); end
      checks++; if (m_address !== 32'h600 || m_writedata !== 16'h3C3C) begin errors++; $display("FAIL t6_data got %h/%h exp 600/3c3c", m_address, m_writedata); end
      @(posedge clk); #1 c0_read = 1'b0; c0_write = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single_read();
      test_tie_after_reset();
      test_hold_limit();
      test_stall_no_switch();
      test_reset_mid_transfer();
      test_rw_both();
      checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", sb_q.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
